// File: rtl/hdmi_i2c_cfg_master.sv
// Avalon-MM slave that issues one 3-byte I2C write (dev addr+W, reg, data)
// per CPU write to program the HDMI transmitter over open-drain SCL/SDA.
module hdmi_i2c_cfg_master #(
  parameter int unsigned CLK_DIV  = 125,
  parameter logic [6:0]  DEV_ADDR = 7'h39
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        scl_out,
  output logic        sda_oe,
  input  logic        sda_in,
  output logic        busy
);

  // state | meaning
  // IDLE  | lines released, waiting for an addr0 write
  // START | S0 both high, S1 SDA pulled low
  // BIT   | B0..B3 per bit, 9 bits per byte (8 data + ACK)
  // STOP  | P0 SCL low/SDA low, P1 SCL high, P2 SDA released
  typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  phase, phase_nxt;
  logic [3:0]  bit_idx, bit_idx_nxt;
  logic [1:0]  byte_idx, byte_idx_nxt;
  logic [15:0] qcnt;
  logic [23:0] shreg;
  logic [15:0] wr_data;
  logic [6:0]  dev_addr;
  logic        ack_err;
  logic        nack;
  logic        wr_en, launch, tick, ack_slot;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[31:16];

  assign wr_en    = chipselect & ~write_n;
  assign launch   = wr_en && (address == 2'd0) && (state == IDLE);
  assign tick     = (state != IDLE) && (qcnt == 16'(CLK_DIV - 1));
  assign ack_slot = (bit_idx == 4'd8);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      qcnt <= '0;
    else if (launch || tick)
      qcnt <= '0;
    else if (state != IDLE)
      qcnt <= qcnt + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      phase    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      bit_idx  <= bit_idx_nxt;
      byte_idx <= byte_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    bit_idx_nxt  = bit_idx;
    byte_idx_nxt = byte_idx;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt    = START;
          phase_nxt    = 2'd0;
          bit_idx_nxt  = 4'd0;
          byte_idx_nxt = 2'd0;
        end
      end
      START: begin
        if (tick) begin
          if (phase == 2'd1) begin
            state_nxt = BIT;
            phase_nxt = 2'd0;
          end else begin
            phase_nxt = phase + 2'd1;
          end
        end
      end
      BIT: begin
        if (tick) begin
          phase_nxt = phase + 2'd1;
          if (phase == 2'd3) begin
            if (!ack_slot) begin
              bit_idx_nxt = bit_idx + 4'd1;
            end else if (nack || (byte_idx == 2'd2)) begin
              state_nxt = STOP;
              phase_nxt = 2'd0;
            end else begin
              bit_idx_nxt  = 4'd0;
              byte_idx_nxt = byte_idx + 2'd1;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (phase == 2'd2) begin
            state_nxt = IDLE;
            phase_nxt = 2'd0;
          end else begin
            phase_nxt = phase + 2'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line levels decode straight from registers so reset releases them at once
  always_comb begin
    scl_out = 1'b1;
    sda_oe  = 1'b0;
    case (state)
      START: sda_oe = (phase == 2'd1);
      BIT: begin
        scl_out = phase[1];
        sda_oe  = ~ack_slot & ~shreg[23];
      end
      STOP: begin
        scl_out = (phase != 2'd0);
        sda_oe  = (phase != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg    <= '0;
      wr_data  <= '0;
      dev_addr <= DEV_ADDR;
      ack_err  <= 1'b0;
      nack     <= 1'b0;
    end else begin
      if (launch) begin
        shreg   <= {dev_addr, 1'b0, writedata[15:0]};
        wr_data <= writedata[15:0];
        ack_err <= 1'b0;
        nack    <= 1'b0;
      end else if ((state == BIT) && tick) begin
        if ((phase == 2'd2) && ack_slot) begin
          nack <= sda_in;
          if (sda_in)
            ack_err <= 1'b1;
        end
        if ((phase == 2'd3) && !ack_slot)
          shreg <= {shreg[22:0], 1'b0};
      end
      if (wr_en && (address == 2'd2) && (state == IDLE))
        dev_addr <= writedata[6:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = {16'd0, wr_data};
      2'd1:    readdata = {30'd0, ack_err, busy};
      2'd2:    readdata = {25'd0, dev_addr};
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hdmi_i2c_cfg_master.sv
// Directed bench: two DUTs (CLK_DIV 4 and 2) sharing one bus, a bus-line
// monitor that decodes I2C bytes, and a simple ACK/NACK slave.
module tb_hdmi_i2c_cfg_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs1, cs2;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd1, rd2;
  logic        scl1, scl2, oe1, oe2, busy1, busy2;
  wire         sda_in;

  logic        sel;
  logic        ack_mode;
  logic        mon_clr;
  logic        slave_pull;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign sda_in = ~(oe1 | oe2 | slave_pull);

  hdmi_i2c_cfg_master #(.CLK_DIV(4), .DEV_ADDR(7'h39)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1),
    .write_n(write_n), .writedata(writedata), .readdata(rd1),
    .scl_out(scl1), .sda_oe(oe1), .sda_in(sda_in), .busy(busy1)
  );

  hdmi_i2c_cfg_master #(.CLK_DIV(2), .DEV_ADDR(7'h39)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2),
    .write_n(write_n), .writedata(writedata), .readdata(rd2),
    .scl_out(scl2), .sda_oe(oe2), .sda_in(sda_in), .busy(busy2)
  );

  wire        scl_m  = sel ? scl2 : scl1;
  wire        oe_m   = sel ? oe2 : oe1;
  wire        busy_m = sel ? busy2 : busy1;
  wire [31:0] rd_m   = sel ? rd2 : rd1;

  // Monitor state
  int         cyc = 0;
  int         npulse, nrise, nstart, nstop, busy_cnt, period, last_rise;
  logic       prev_scl = 1'b1, prev_oe = 1'b0;
  logic       pending, pend_bit;
  logic [7:0] shreg;
  logic [7:0] byts [3];

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_scl <= scl_m;
    prev_oe  <= oe_m;
    if (mon_clr) begin
      npulse <= 0; nrise <= 0; nstart <= 0; nstop <= 0; busy_cnt <= 0;
      period <= 0; last_rise <= 0; pending <= 1'b0; pend_bit <= 1'b0;
      shreg <= '0; slave_pull <= 1'b0;
      byts[0] <= '0; byts[1] <= '0; byts[2] <= '0;
    end else begin
      if (busy_m) busy_cnt <= busy_cnt + 1;
      if (prev_scl && scl_m && !prev_oe && oe_m) nstart <= nstart + 1;
      if (prev_scl && scl_m && prev_oe && !oe_m) begin
        nstop   <= nstop + 1;
        pending <= 1'b0;
      end
      if (!prev_scl && scl_m) begin
        pending   <= 1'b1;
        pend_bit  <= sda_in;
        nrise     <= nrise + 1;
        last_rise <= cyc;
        if (nrise == 1) period <= cyc - last_rise;
      end
      // a pulse counts only once SCL falls again, so the STOP rise is excluded
      if (prev_scl && !scl_m && pending) begin
        pending <= 1'b0;
        npulse  <= npulse + 1;
        if ((npulse % 9) != 8) shreg <= {shreg[6:0], pend_bit};
        if (((npulse % 9) == 7) && ((npulse / 9) < 3))
          byts[npulse / 9] <= {shreg[6:0], pend_bit};
        slave_pull <= !ack_mode && (((npulse + 1) % 9) == 8);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    @(posedge clk);
    mon_clr = 1'b1;
    @(posedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d, input int which);
    @(negedge clk);
    address = a; writedata = d; write_n = 1'b0;
    cs1 = (which == 1); cs2 = (which == 2);
    @(negedge clk);
    write_n = 1'b1; cs1 = 1'b0; cs2 = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, rd_m, exp);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_m && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 5000), 32'd1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; address = '0; cs1 = 1'b0; cs2 = 1'b0; write_n = 1'b1;
    writedata = '0; sel = 1'b0; ack_mode = 1'b0; mon_clr = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;

    check("rst_scl", 32'(scl1), 32'd1);
    check("rst_oe", 32'(oe1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    read_chk("rst_status", 2'd1, 32'h0);
    read_chk("rst_devaddr", 2'd2, 32'h39);

    // Normal transaction with ignored writes mid-flight and on the last cycle
    clr_mon();
    @(negedge clk);
    address = 2'd0; writedata = 32'h4110; write_n = 1'b0; cs1 = 1'b1;
    @(negedge clk);
    write_n = 1'b1; cs1 = 1'b0;
    check("launch_busy", 32'(busy1), 32'd1);
    repeat (49) @(negedge clk);
    address = 2'd0; writedata = 32'h1234; write_n = 1'b0; cs1 = 1'b1;
    @(negedge clk);
    address = 2'd2; writedata = 32'h55;
    @(negedge clk);
    write_n = 1'b1; cs1 = 1'b0;
    repeat (400) @(negedge clk);
    check("last_cycle_busy", 32'(busy1), 32'd1);
    address = 2'd0; writedata = 32'h5678; write_n = 1'b0; cs1 = 1'b1;
    @(negedge clk);
    write_n = 1'b1; cs1 = 1'b0;
    check("end_write_ignored", 32'(busy1), 32'd0);
    repeat (100) @(negedge clk);
    check("norm_busy_after", 32'(busy1), 32'd0);
    check("norm_byte0", 32'(byts[0]), 32'h72);
    check("norm_byte1", 32'(byts[1]), 32'h41);
    check("norm_byte2", 32'(byts[2]), 32'h10);
    check("norm_pulses", 32'(npulse), 32'd27);
    check("norm_starts", 32'(nstart), 32'd1);
    check("norm_stops", 32'(nstop), 32'd1);
    check("norm_busy_cycles", 32'(busy_cnt), 32'd452);
    read_chk("norm_status", 2'd1, 32'h0);
    read_chk("norm_devaddr", 2'd2, 32'h39);
    read_chk("norm_wrdata", 2'd0, 32'h4110);

    // Address NACK
    clr_mon();
    ack_mode = 1'b1;
    do_write(2'd0, 32'h4110, 1);
    wait_idle("nack_timeout");
    check("nack_byte0", 32'(byts[0]), 32'h72);
    check("nack_pulses", 32'(npulse), 32'd9);
    check("nack_stops", 32'(nstop), 32'd1);
    check("nack_busy_cycles", 32'(busy_cnt), 32'd164);
    read_chk("nack_status", 2'd1, 32'h2);

    // Reset during the second data bit
    ack_mode = 1'b0;
    clr_mon();
    do_write(2'd0, 32'h4110, 1);
    begin
      int n = 0;
      while (nrise < 2 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("bit2_reached", 32'(n < 1000), 32'd1);
    end
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_scl", 32'(scl1), 32'd1);
    check("rst_mid_oe", 32'(oe1), 32'd0);
    check("rst_mid_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clr_mon();
    do_write(2'd0, 32'hA55A, 1);
    wait_idle("post_rst_timeout");
    check("post_rst_byte0", 32'(byts[0]), 32'h72);
    check("post_rst_byte1", 32'(byts[1]), 32'hA5);
    check("post_rst_byte2", 32'(byts[2]), 32'h5A);
    check("post_rst_pulses", 32'(npulse), 32'd27);
    check("post_rst_busy_cycles", 32'(busy_cnt), 32'd452);

    // CLK_DIV=2 instance, new device address, NACK then clean retry
    @(negedge clk);
    sel = 1'b1;
    ack_mode = 1'b1;
    clr_mon();
    do_write(2'd2, 32'h3D, 2);
    do_write(2'd0, 32'h00FF, 2);
    wait_idle("div2_nack_timeout");
    check("div2_byte0", 32'(byts[0]), 32'h7A);
    check("div2_scl_period", 32'(period), 32'd8);
    check("div2_nack_busy_cycles", 32'(busy_cnt), 32'd82);
    read_chk("div2_nack_status", 2'd1, 32'h2);
    read_chk("div2_devaddr", 2'd2, 32'h3D);

    ack_mode = 1'b0;
    clr_mon();
    do_write(2'd0, 32'h00FF, 2);
    read_chk("div2_relaunch_status", 2'd1, 32'h1);
    wait_idle("div2_ack_timeout");
    check("div2_ack_byte0", 32'(byts[0]), 32'h7A);
    check("div2_ack_byte1", 32'(byts[1]), 32'h00);
    check("div2_ack_byte2", 32'(byts[2]), 32'hFF);
    check("div2_ack_pulses", 32'(npulse), 32'd27);
    check("div2_ack_busy_cycles", 32'(busy_cnt), 32'd226);
    read_chk("div2_ack_status", 2'd1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
